// File: rtl/gate_tt_identifier_pkg.sv
// rtl/gate_tt_identifier_pkg.sv - shared encodings for the gate truth-table identifier
// Contents: gate_id encodings, FSM state type, reference truth-table patterns.
package gate_tt_identifier_pkg;

  localparam logic [2:0] GID_UNKNOWN = 3'd0;
  localparam logic [2:0] GID_AND     = 3'd1;
  localparam logic [2:0] GID_NAND    = 3'd2;
  localparam logic [2:0] GID_OR      = 3'd3;
  localparam logic [2:0] GID_NOR     = 3'd4;
  localparam logic [2:0] GID_XOR     = 3'd5;
  localparam logic [2:0] GID_XNOR    = 3'd6;
  localparam logic [2:0] GID_STUCK   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Truth patterns, bit i = output for {a,b} == i (bit 3 is vector 11).
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;
  localparam logic [3:0] TT_LOW  = 4'b0000;
  localparam logic [3:0] TT_HIGH = 4'b1111;

endpackage

// File: rtl/gate_tt_identifier_tt_decode.sv
// rtl/gate_tt_identifier_tt_decode.sv - combinational truth-table to gate identity decoder
// Ports:
//   truth   in  4  observed truth table, bit i = output for {a,b} == i
//   gate_id out 3  decoded gate identity (GID_* encodings)
module tt_decode
  import gate_tt_identifier_pkg::*;
(
  input  logic [3:0] truth,
  output logic [2:0] gate_id
);

  always_comb begin
    gate_id = GID_UNKNOWN;
    case (truth)
      TT_AND:          gate_id = GID_AND;
      TT_NAND:         gate_id = GID_NAND;
      TT_OR:           gate_id = GID_OR;
      TT_NOR:          gate_id = GID_NOR;
      TT_XOR:          gate_id = GID_XOR;
      TT_XNOR:         gate_id = GID_XNOR;
      TT_LOW, TT_HIGH: gate_id = GID_STUCK;
      default:         gate_id = GID_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/gate_tt_identifier.sv
// rtl/gate_tt_identifier.sv - sweeps a 2-input gate through all vectors and identifies it
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous active-high reset
//   start    in   1  sweep request, honoured only in IDLE
//   y        in   1  output of the gate under test
//   a, b     out  1  registered drive to the gate under test
//   busy     out  1  high during SETTLE and SAMPLE
//   done     out  1  one-cycle pulse, results valid in the same cycle
//   truth    out  4  truth table of the last completed sweep
//   gate_id  out  3  decoded identity of the last completed sweep
module gate_tt_identifier
  import gate_tt_identifier_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic [2:0] gate_id
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..255");
  end

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state, next_state;
  logic [7:0] cnt;
  logic [1:0] idx;
  logic [3:0] shadow;
  logic [3:0] shadow_next;
  logic [2:0] decoded;

  // Shadow with the current sample merged in, so the final vector's bit
  // reaches truth/gate_id on the same edge that enters DONE.
  always_comb begin
    shadow_next      = shadow;
    shadow_next[idx] = y;
  end

  tt_decode u_decode (
    .truth   (shadow_next),
    .gate_id (decoded)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_SETTLE;
      ST_SETTLE: if (cnt == CNT_LAST) next_state = ST_SAMPLE;
      ST_SAMPLE: next_state = (idx == 2'd3) ? ST_DONE : ST_SETTLE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a       <= 1'b0;
      b       <= 1'b0;
      cnt     <= 8'd0;
      idx     <= 2'd0;
      shadow  <= 4'd0;
      truth   <= 4'd0;
      gate_id <= GID_UNKNOWN;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx    <= 2'd0;
            a      <= 1'b0;
            b      <= 1'b0;
            cnt    <= 8'd0;
            shadow <= 4'd0;
          end
        end
        ST_SETTLE: cnt <= cnt + 8'd1;
        ST_SAMPLE: begin
          shadow <= shadow_next;
          if (idx == 2'd3) begin
            truth   <= shadow_next;
            gate_id <= decoded;
          end else begin
            idx    <= idx + 2'd1;
            {a, b} <= idx + 2'd1;
            cnt    <= 8'd0;
          end
        end
        ST_DONE: begin
          a <= 1'b0;
          b <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_gate_tt_identifier.sv
// tb/tb_gate_tt_identifier.sv - directed self-checking bench for gate_tt_identifier
module tb_gate_tt_identifier;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start1;
  logic       y, y1;
  logic       a, b, busy, done;
  logic       a1, b1, busy1, done1;
  logic [3:0] truth, truth1;
  logic [2:0] gate_id, gate_id1;
  int         mode;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate under test for the default-settle instance.
  always_comb begin
    case (mode)
      0:       y = ~(a & b);
      1:       y = ~(a | b);
      2:       y = a ^ b;
      3:       y = 1'b1;
      4:       y = a;
      default: y = a & b;
    endcase
  end

  // Registered NOR for the SETTLE_CYCLES=1 instance.
  always @(posedge clk) y1 <= ~(a1 | b1);

  gate_tt_identifier #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .y(y),
    .a(a), .b(b), .busy(busy), .done(done), .truth(truth), .gate_id(gate_id)
  );

  gate_tt_identifier #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .y(y1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .truth(truth1), .gate_id(gate_id1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One pulsed sweep; a stray start during busy must be ignored.
  task automatic sweep(input string name, input logic [3:0] exp_tt, input logic [2:0] exp_gid,
                       input bit trace);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 10) start = 1'b1;
      if (k == 11) start = 1'b0;
      if (k <= 20 && trace) begin
        check($sformatf("%s_busy_c%0d", name, k), busy, 1);
        check($sformatf("%s_ab_c%0d", name, k), {a, b}, (k - 1) / 5);
        check($sformatf("%s_done_c%0d", name, k), done, 0);
      end
      if (k == 21) begin
        check($sformatf("%s_done_c21", name), done, 1);
        check($sformatf("%s_busy_c21", name), busy, 0);
        check($sformatf("%s_truth", name), truth, exp_tt);
        check($sformatf("%s_gid", name), gate_id, exp_gid);
      end
      if (k == 22) begin
        check($sformatf("%s_done_c22", name), done, 0);
        check($sformatf("%s_ab_c22", name), {a, b}, 0);
      end
    end
  endtask

  initial begin
    int t[$];
    int ndone;
    int first_k;
    bit prev_done;

    rst = 1'b1; start = 1'b0; start1 = 1'b0; mode = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ab", {a, b}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_truth", truth, 0);
    check("rst_gid", gate_id, 0);

    mode = 0; sweep("nand", 4'b0111, 3'd2, 1'b1);
    mode = 1; sweep("nor",  4'b0001, 3'd4, 1'b0);
    mode = 2; sweep("xor",  4'b0110, 3'd5, 1'b0);
    mode = 3; sweep("one",  4'b1111, 3'd7, 1'b0);
    mode = 4; sweep("ya",   4'b1100, 3'd0, 1'b0);

    // Start held high: back-to-back sweeps with one IDLE cycle between.
    mode = 0;
    prev_done = 1'b0;
    @(negedge clk) start = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (prev_done) begin
        check("hold_idle_busy", busy, 0);
        check("hold_idle_done", done, 0);
      end
      if (done) begin
        t.push_back(cyc);
        check("hold_truth", truth, 4'b0111);
      end
      prev_done = done;
    end
    start = 1'b0;
    check("hold_ndone", t.size(), 3);
    if (t.size() >= 3) begin
      check("hold_gap1", t[1] - t[0], 22);
      check("hold_gap2", t[2] - t[1], 22);
    end
    repeat (30) @(negedge clk);

    // Reset mid-sweep while {a,b}=10.
    mode = 5;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(negedge clk);
    check("mid_ab_before", {a, b}, 2'b10);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_ab", {a, b}, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_truth", truth, 0);
    check("mid_gid", gate_id, 0);
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mid_no_done", ndone, 0);
    sweep("and", 4'b1000, 3'd1, 1'b0);

    // SETTLE_CYCLES=1 with a registered NOR.
    first_k = 0;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done1 && first_k == 0) begin
        first_k = k;
        check("s1_truth", truth1, 4'b0001);
        check("s1_gid", gate_id1, 3'd4);
      end
    end
    check("s1_done_cycle", first_k, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
